// File: rtl/demux1_3_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cgra_pkg
// Description : Shared CGRA interconnect constants: destination select codes
//               and the default datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package cgra_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [1:0] DEST_P1      = 2'b00;
    localparam logic [1:0] DEST_P2      = 2'b01;
    localparam logic [1:0] DEST_P3      = 2'b10;
    localparam logic [1:0] DEST_ILLEGAL = 2'b11;

endpackage : cgra_pkg
`default_nettype wire

// File: rtl/demux1_3_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : demux1_3_stream_if
// Description : Producer/consumer bundle for the 1-to-3 stream demux.
//               Statistics counters exist only with DEMUX1_3_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface demux1_3_stream_if #(
    parameter int unsigned WIDTH = cgra_pkg::DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       sel;
    logic             out_1_valid;
    logic             out_2_valid;
    logic             out_3_valid;
    logic             out_1_ready;
    logic             out_2_ready;
    logic             out_3_ready;
    logic [WIDTH-1:0] data_out_1;
    logic [WIDTH-1:0] data_out_2;
    logic [WIDTH-1:0] data_out_3;
    logic             sel_err;
`ifdef DEMUX1_3_STATS_EN
    logic [15:0]      cnt_1;
    logic [15:0]      cnt_2;
    logic [15:0]      cnt_3;
    logic [7:0]       cnt_drop;
`endif

    modport slave (
        input  in_valid, in_data, sel, out_1_ready, out_2_ready, out_3_ready,
        output in_ready, out_1_valid, out_2_valid, out_3_valid,
        output data_out_1, data_out_2, data_out_3, sel_err
`ifdef DEMUX1_3_STATS_EN
        , output cnt_1, cnt_2, cnt_3, cnt_drop
`endif
    );

    modport master (
        output in_valid, in_data, sel, out_1_ready, out_2_ready, out_3_ready,
        input  in_ready, out_1_valid, out_2_valid, out_3_valid,
        input  data_out_1, data_out_2, data_out_3, sel_err
`ifdef DEMUX1_3_STATS_EN
        , input cnt_1, cnt_2, cnt_3, cnt_drop
`endif
    );

endinterface : demux1_3_stream_if
`default_nettype wire

// File: rtl/demux1_3_stream_slot.sv
`default_nettype none
// ============================================================================
// Module      : stream_slot
// Description : Single-entry valid/ready buffer; a fill wins over a drain so
//               the slot sustains one word per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_slot #(
    parameter int unsigned WIDTH = cgra_pkg::DEFAULT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_fill,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_ready,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            // Drain only: data is held so the consumer bus stays quiet.
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule : stream_slot
`default_nettype wire

// File: rtl/demux1_3_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux1_3_stream
// Description : Routes one producer word to one of three buffered consumer
//               ports. Optional counters enabled by DEMUX1_3_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module demux1_3_stream
    import cgra_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    demux1_3_stream_if.slave   bus
);

    logic [2:0]       w_valid;
    logic [2:0]       w_ready;
    logic [2:0]       w_fill;
    logic [2:0]       w_free;
    logic [WIDTH-1:0] w_data [3];
    logic             w_illegal;
    logic             w_accept;
    logic             w_in_ready;
    logic             r_sel_err;

    assign w_ready   = {bus.out_3_ready, bus.out_2_ready, bus.out_1_ready};
    assign w_free    = ~w_valid | w_ready;
    assign w_illegal = (bus.sel == DEST_ILLEGAL);

    // Ready ignores in_valid so the producer never sees a combinational loop.
    always_comb begin
        w_in_ready = 1'b1;
        case (bus.sel)
            DEST_P1: w_in_ready = w_free[0];
            DEST_P2: w_in_ready = w_free[1];
            DEST_P3: w_in_ready = w_free[2];
            default: w_in_ready = 1'b1;
        endcase
    end

    assign w_accept  = bus.in_valid && w_in_ready;
    assign w_fill[0] = w_accept && (bus.sel == DEST_P1);
    assign w_fill[1] = w_accept && (bus.sel == DEST_P2);
    assign w_fill[2] = w_accept && (bus.sel == DEST_P3);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            stream_slot #(.WIDTH(WIDTH)) u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_fill  (w_fill[gi]),
                .i_data  (bus.in_data),
                .i_ready (w_ready[gi]),
                .o_valid (w_valid[gi]),
                .o_data  (w_data[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sel_err <= 1'b0;
        else if (bus.in_valid && w_illegal)
            r_sel_err <= 1'b1;
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_1_valid = w_valid[0];
    assign bus.out_2_valid = w_valid[1];
    assign bus.out_3_valid = w_valid[2];
    assign bus.data_out_1  = w_data[0];
    assign bus.data_out_2  = w_data[1];
    assign bus.data_out_3  = w_data[2];
    assign bus.sel_err     = r_sel_err;

`ifdef DEMUX1_3_STATS_EN
    logic [15:0] r_cnt_1;
    logic [15:0] r_cnt_2;
    logic [15:0] r_cnt_3;
    logic [7:0]  r_cnt_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_1    <= '0;
            r_cnt_2    <= '0;
            r_cnt_3    <= '0;
            r_cnt_drop <= '0;
        end else begin
            if (w_fill[0])                   r_cnt_1    <= r_cnt_1 + 16'd1;
            if (w_fill[1])                   r_cnt_2    <= r_cnt_2 + 16'd1;
            if (w_fill[2])                   r_cnt_3    <= r_cnt_3 + 16'd1;
            if (bus.in_valid && w_illegal)   r_cnt_drop <= r_cnt_drop + 8'd1;
        end
    end

    assign bus.cnt_1    = r_cnt_1;
    assign bus.cnt_2    = r_cnt_2;
    assign bus.cnt_3    = r_cnt_3;
    assign bus.cnt_drop = r_cnt_drop;
`endif

endmodule : demux1_3_stream
`default_nettype wire

// File: doc/demux1_3_stream.md
Name: demux1_3_stream

Overview:
- 1-to-3 steering block, the inverse of the 3-to-1 operand mux; used on the CGRA interconnect to route one 32-bit producer word to one of three consumer ports.
- Each output port has a one-entry registered buffer with valid/ready handshake, so one consumer stalling does not block traffic bound for the other two.
- Sits between a PE result bus and three neighbour PE input ports.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- sel  input  2  destination: 00 goes to port 1, 01 to port 2, 10 to port 3, 11 is illegal.
- out_1_valid, out_2_valid, out_3_valid  output  1 each  buffer for that port holds a word.
- out_1_ready, out_2_ready, out_3_ready  input  1 each  consumer takes the word this cycle.
- data_out_1, data_out_2, data_out_3  output  WIDTH each  buffered word for that port.
- sel_err  output  1  sticky flag: an illegal sel was presented with in_valid.

Behaviour:
- Reset, asynchronous, active-high:
  - all out_N_valid = 0, all data_out_N = 0, sel_err = 0.
  - Reset asserted mid-operation discards buffered words immediately, with no handshake.
- Per-port buffer N:
  - Drain: occurs when out_N_valid && out_N_ready.
  - Fill: occurs when in_valid && in_ready && sel selects N.
  - Fill only, or fill and drain in the same cycle: load in_data and set valid = 1. Simultaneous drain and fill sustains 1 word/cycle per port.
  - Drain only: clear valid. data_out_N holds its last value.
- in_ready is combinational from sel and the target port state:
  - For a legal sel: in_ready = !out_N_valid || out_N_ready.
  - For sel = 11: in_ready = 1. The word is consumed and dropped, and sel_err is set on that edge if in_valid.
  - in_ready does not depend on in_valid.
- sel_err stays 1 until reset.
- Latency: a word accepted at edge k appears on data_out_N with out_N_valid = 1 after edge k.
- Non-target ports are unaffected by a transfer; they may drain in the same cycle.
- Ordering: words to the same port leave in acceptance order. There is no ordering guarantee across ports.
- Rules for the producer:
  - in_valid with in_data/sel must stay stable until in_ready.
  - The block never deasserts out_N_valid or changes data_out_N without a drain or a reset.

Optional Feature:
- Macro: DEMUX1_3_STATS_EN.
- Defined:
  - Adds output ports cnt_1, cnt_2, cnt_3 (16 bits each) and cnt_drop (8 bits).
  - cnt_N counts accepted words per port; cnt_drop counts illegal-sel words.
  - All counters reset to 0, wrap modulo 2^16 (or 2^8 for cnt_drop), and increment on the accepting edge.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package `cgra_pkg`:
  - DEST_P1 = 2'b00, DEST_P2 = 2'b01, DEST_P3 = 2'b10, DEST_ILLEGAL = 2'b11.
  - Default WIDTH = 32.
- One sub-module, `stream_slot`: a single-entry valid/ready buffer with fill/drain logic, instantiated three times.
- The top level holds the sel decode, in_ready mux, sel_err and the optional counters.

Test Plan:
- Reset, then in_valid = 1, in_data = A5A5A5A5, sel = 00 → after 1 edge: out_1_valid = 1, data_out_1 = A5A5A5A5; out_2/out_3 valid remain 0.
- Port 2 full with out_2_ready = 0, new word 5A5A5A5A with sel = 01 → in_ready = 0. Assert out_2_ready → transfer accepted the same cycle; data_out_2 = 5A5A5A5A next cycle.
- Back-to-back streaming to port 3 (12345678, DEADBEEF, FFFFFFFF) with out_3_ready held at 1 → one word per cycle in order, in_ready constantly 1.
- Port 1 stalled full while a word with sel = 10 is sent → accepted on port 3 without waiting.
- in_valid = 1, sel = 11, data 00000000 → in_ready = 1, no out_N_valid change, sel_err = 1 and it stays 1. With DEMUX1_3_STATS_EN, cnt_drop = 1.
- Port 1 holds a word, then rst pulses asynchronously between edges → out_1_valid = 0 immediately; sel_err = 0 and counters = 0.
